s420_ctl_loader: RTL
====================

# s420_ctl_loader

Upstream control stage for the s420 counter/comparator. Serially loads a 17-bit compare word into a shadow register, commits it atomically to the parallel compare lines C_0..C_16, and generates the count-enable P_0 from a small run/stop state machine. On every commit, P_0 is forced low for exactly one cycle, so the counter never sees a half-updated compare word.

## Interface
- No parameters. The word width is fixed at 17, matching C_0..C_16.
- CK  input  1  clock; all state updates on the rising edge
- RST  input  1  reset; asynchronous, active-high
- SI  input  1  serial compare-word data, LSB first
- SV  input  1  SI valid; a bit is accepted when SV=1 and RDY=1
- LD  input  1  commit request for the shadow word
- RUN  input  1  request counting
- STOP  input  1  request halt; takes priority over RUN
- C_0 … C_16  output  1 each  committed compare word; C_0 is the LSB
- P_0  output  1  counter enable to s420
- RDY  output  1  shadow register can accept a bit
- ACK  output  1  one-cycle pulse: commit done
- ERR  output  1  one-cycle pulse: LD rejected
- ST_1, ST_0  output  1 each  run-FSM state code

## Operation
- Shift path: 17-bit shadow register SH and a 5-bit count CNT (range 0..17). RDY = (CNT<17).
- On SV&RDY: SH shifts right, SI enters SH[16], CNT increments. After 17 accepted bits, the first bit sent sits in SH[0].
- SV while RDY=0: ignored. SH and CNT hold.
- Commit: LD while CNT==17:
  - next edge: C <= SH, CNT <= 0, internal flag CV <= 1
  - ACK=1 for that one cycle
  - SH contents are retained but become don't-care
- LD while CNT<17: no state change except ERR=1 for one cycle. A bit accepted in the same cycle still counts.
- Run FSM, states (ST_1,ST_0):
  - STOPPED=00
  - RUNNING=01
  - HOLD=10
  - Code 11 is unreachable and decodes to STOPPED on the next edge.
- Transitions, in priority order:
  - STOP=1 → STOPPED from any state.
  - RUNNING with a commit this cycle → HOLD.
  - HOLD → RUNNING unconditionally after one cycle, unless STOP.
  - STOPPED with RUN=1 and CV=1 → RUNNING. Also allowed when CV becomes 1 on the same edge via commit.
  - RUN with CV=0 → stays STOPPED.
- P_0 = 1 only in RUNNING. It is decoded from registered state only, so it is glitch-free.
- The C outputs change only on a commit edge.

## Timing
- Reset, asynchronous and immediate:
  - C_0..C_16=0, SH=0, CNT=0, CV=0
  - state STOPPED; P_0=0, ST=00
  - RDY=1, ACK=0, ERR=0
- After RST falls, the first accepted bit is possible on the next rising CK edge.
- Minimum load-to-commit: 17 cycles of SV, then LD. The earliest LD is the cycle after the 17th bit. ACK and new C appear 1 cycle after the LD edge.
- RUN→P_0 latency: 1 cycle.
- STOP→P_0 low: 1 cycle.
- Commit while RUNNING: P_0 low for exactly 1 cycle, the same cycle the new C appears, then high again.
- Reset asserted mid-fill: partial word discarded. CNT=0 and RDY=1 immediately.
- Back-to-back fill: SV may be held high across the commit cycle. Bits resume being accepted the cycle after commit (RDY=1 once CNT=0).
- ACK and ERR are mutually exclusive and never assert for more than 1 cycle per LD. LD held high produces repeated ERR pulses until CNT==17, then one ACK.

## Test plan
- Reset: hold RST 3 cycles mid-stream with SV=1 → C=0, P_0=0, RDY=1, ST=00 throughout; CNT restarts from 0 after release.
- Load 0x10005, bits 1,0,1,0,0,…,0,1 LSB first over 17 cycles, then LD → RDY=0 after bit 17; next cycle ACK=1 and C_0=1, C_2=1, C_16=1, all other C=0.
- LD after only 16 bits → ERR=1 for 1 cycle, C unchanged, RDY=1. One more bit then LD → ACK.
- RUN=1 before any commit → P_0 stays 0. Commit, then RUN → P_0=1 one cycle later. RUN=1 and STOP=1 together → P_0=0, ST=00.
- While RUNNING, commit a new word 0x00003 → exactly one cycle with ST=10 and P_0=0, coincident with C changing, then P_0=1.
- SV held high for 20 cycles, then LD → only the first 17 bits are captured; bits 18–20 are ignored; committed value equals the first 17 SI bits.

Source files
------------

// File: rtl/s420_ctl_loader.sv
// Control loader for the s420 counter: serial shadow fill, atomic commit to C_0..C_16,
// and run/stop FSM driving the count enable P_0 with a one-cycle hold on every commit.
`timescale 1ns/1ps
module s420_ctl_loader (
    input  logic CK,
    input  logic RST,
    input  logic SI,
    input  logic SV,
    input  logic LD,
    input  logic RUN,
    input  logic STOP,
    output logic C_0,
    output logic C_1,
    output logic C_2,
    output logic C_3,
    output logic C_4,
    output logic C_5,
    output logic C_6,
    output logic C_7,
    output logic C_8,
    output logic C_9,
    output logic C_10,
    output logic C_11,
    output logic C_12,
    output logic C_13,
    output logic C_14,
    output logic C_15,
    output logic C_16,
    output logic P_0,
    output logic RDY,
    output logic ACK,
    output logic ERR,
    output logic ST_1,
    output logic ST_0
);

    typedef enum logic [1:0] {
        StStopped = 2'b00,
        StRunning = 2'b01,
        StHold    = 2'b10
    } state_e;

    logic [16:0] sh_q, sh_d;
    logic [16:0] c_q, c_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        cv_q, cv_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;
    state_e      state_q, state_d;

    logic        accept;
    logic        commit;

    assign accept = SV && (cnt_q < 5'd17);
    assign commit = LD && (cnt_q == 5'd17);

    always_comb begin
        sh_d  = sh_q;
        c_d   = c_q;
        cnt_d = cnt_q;
        cv_d  = cv_q;
        ack_d = commit;
        err_d = LD && !commit;
        if (commit) begin
            c_d   = sh_q;
            cnt_d = 5'd0;
            cv_d  = 1'b1;
        end else if (accept) begin
            sh_d  = {SI, sh_q[16:1]};
            cnt_d = cnt_q + 5'd1;
        end
    end

    always_comb begin
        state_d = StStopped;
        if (!STOP) begin
            case (state_q)
                StRunning: state_d = commit ? StHold : StRunning;
                StHold:    state_d = StRunning;
                // cv_d already reflects a commit landing on this same edge
                StStopped: state_d = (RUN && cv_d) ? StRunning : StStopped;
                default:   state_d = StStopped;
            endcase
        end
    end

    always_ff @(posedge CK or posedge RST) begin
        if (RST) begin
            sh_q    <= 17'd0;
            c_q     <= 17'd0;
            cnt_q   <= 5'd0;
            cv_q    <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            state_q <= StStopped;
        end else begin
            sh_q    <= sh_d;
            c_q     <= c_d;
            cnt_q   <= cnt_d;
            cv_q    <= cv_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            state_q <= state_d;
        end
    end

    assign RDY  = (cnt_q < 5'd17);
    assign ACK  = ack_q;
    assign ERR  = err_q;
    assign P_0  = (state_q == StRunning);
    assign ST_1 = state_q[1];
    assign ST_0 = state_q[0];

    assign C_0  = c_q[0];
    assign C_1  = c_q[1];
    assign C_2  = c_q[2];
    assign C_3  = c_q[3];
    assign C_4  = c_q[4];
    assign C_5  = c_q[5];
    assign C_6  = c_q[6];
    assign C_7  = c_q[7];
    assign C_8  = c_q[8];
    assign C_9  = c_q[9];
    assign C_10 = c_q[10];
    assign C_11 = c_q[11];
    assign C_12 = c_q[12];
    assign C_13 = c_q[13];
    assign C_14 = c_q[14];
    assign C_15 = c_q[15];
    assign C_16 = c_q[16];

endmodule
